// File: rtl/levenshtein_core.sv
// rtl/levenshtein_core.sv - edit-distance engine, single-row DP buffer on the stack, bus master
// One bus transaction per state visit; a full row is rebuilt for every character of string a.

module levenshtein_core (
  input  logic        clk,
  input  logic        rstb,
  input  logic        setb,
  output logic        idle,
  input  logic [7:0]  pc0,
  input  logic [31:0] ra0,
  input  logic [31:0] sp0,
  input  logic [31:0] s00,
  input  logic [31:0] a00,
  input  logic [31:0] a10,
  input  logic [31:0] a20,
  input  logic [31:0] a30,
  input  logic [31:0] a40,
  output logic [31:0] a0,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        valid,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);

  typedef enum logic [3:0] {
    S_LOAD, S_INIT, S_ROWSTART, S_RD_A, S_RD_B, S_RD_V, S_WR_V, S_FINISH, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_pc_bad;
  logic [31:0] r_a_p, r_m, r_b_p, r_n, r_base;
  logic [31:0] r_i, r_j, r_prev, r_left, r_t, r_a0;
  logic [7:0]  r_ca, r_cb;
  logic        r_valid, r_write;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_size;

  logic        w_done, w_bus, w_issue, w_row_last, w_col_last;
  logic [31:0] w_x, w_t1, w_l1, w_d, w_min_tl, w_row_addr;
  logic [31:0] w_req_addr, w_req_wdata;
  logic [2:0]  w_req_size;
  logic        w_req_write;
  logic        w_unused;

  // Captured-but-unused call arguments.
  assign w_unused = ^{ra0, s00, a40};

  assign w_done     = r_valid & ready;
  assign w_bus      = (r_state == S_INIT) || (r_state == S_ROWSTART) || (r_state == S_RD_A) ||
                      (r_state == S_RD_B) || (r_state == S_RD_V) || (r_state == S_WR_V);
  assign w_issue    = setb & w_bus & ~r_valid;
  assign w_row_last = (r_i == r_m);
  assign w_col_last = (r_j == r_n);
  assign w_row_addr = r_base + {r_j[29:0], 2'b00};

  assign w_t1     = r_t + 32'd1;
  assign w_l1     = r_left + 32'd1;
  assign w_d      = r_prev + {31'd0, (r_ca != r_cb)};
  assign w_min_tl = (w_t1 < w_l1) ? w_t1 : w_l1;
  assign w_x      = (w_d < w_min_tl) ? w_d : w_min_tl;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) r_state <= S_LOAD;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!setb) begin
      w_state_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:     w_state_next = r_pc_bad ? S_DONE : S_INIT;
        S_INIT:     if (w_done && w_col_last) w_state_next = (r_m == 32'd0) ? S_FINISH : S_ROWSTART;
        S_ROWSTART: if (w_done) w_state_next = S_RD_A;
        S_RD_A: begin
          if (w_done) begin
            if (r_n != 32'd0) w_state_next = S_RD_B;
            else              w_state_next = w_row_last ? S_FINISH : S_ROWSTART;
          end
        end
        S_RD_B:     if (w_done) w_state_next = S_RD_V;
        S_RD_V:     if (w_done) w_state_next = S_WR_V;
        S_WR_V: begin
          if (w_done) begin
            if (!w_col_last)     w_state_next = S_RD_B;
            else if (w_row_last) w_state_next = S_FINISH;
            else                 w_state_next = S_ROWSTART;
          end
        end
        S_FINISH:   w_state_next = S_DONE;
        S_DONE:     w_state_next = S_DONE;
        default:    w_state_next = S_LOAD;
      endcase
    end
  end

  always_comb begin
    w_req_addr  = 32'd0;
    w_req_size  = 3'd0;
    w_req_write = 1'b0;
    w_req_wdata = 32'd0;
    case (r_state)
      S_INIT:     begin w_req_addr = w_row_addr; w_req_size = 3'd2; w_req_write = 1'b1; w_req_wdata = r_j; end
      S_ROWSTART: begin w_req_addr = r_base;     w_req_size = 3'd2; w_req_write = 1'b1; w_req_wdata = r_i; end
      S_RD_A:     begin w_req_addr = r_a_p + r_i - 32'd1; end
      S_RD_B:     begin w_req_addr = r_b_p + r_j - 32'd1; end
      S_RD_V:     begin w_req_addr = w_row_addr; w_req_size = 3'd2; end
      S_WR_V:     begin w_req_addr = w_row_addr; w_req_size = 3'd2; w_req_write = 1'b1; w_req_wdata = w_x; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_pc_bad <= 1'b0;
      r_a_p    <= '0; r_m <= '0; r_b_p <= '0; r_n <= '0; r_base <= '0;
      r_i      <= '0; r_j <= '0; r_prev <= '0; r_left <= '0; r_t <= '0;
      r_ca     <= '0; r_cb <= '0;
      r_a0     <= '0;
      r_valid  <= 1'b0; r_write <= 1'b0; r_addr <= '0; r_size <= '0; r_wdata <= '0;
    end else if (!setb) begin
      r_valid  <= 1'b0;
      r_pc_bad <= (pc0 != 8'd0);
      r_a_p    <= a00;
      r_m      <= a10;
      r_b_p    <= a20;
      r_n      <= a30;
      r_base   <= sp0 - ((a30 + 32'd1) << 2);
    end else begin
      if (w_issue) begin
        r_valid <= 1'b1;
        r_addr  <= w_req_addr;
        r_size  <= w_req_size;
        r_write <= w_req_write;
        r_wdata <= w_req_wdata;
      end else if (w_done) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_LOAD: begin
          r_i <= 32'd1;
          r_j <= 32'd0;
          if (r_pc_bad) r_a0 <= 32'd0;
        end
        S_INIT: begin
          if (w_done) begin
            if (w_col_last) begin
              r_left <= r_n;
              if (r_m == 32'd0) r_a0 <= r_n;
            end else begin
              r_j <= r_j + 32'd1;
            end
          end
        end
        S_ROWSTART: begin
          if (w_done) begin
            r_prev <= r_i - 32'd1;
            r_left <= r_i;
          end
        end
        S_RD_A: begin
          if (w_done) begin
            r_ca <= rdata[7:0];
            r_j  <= 32'd1;
            if (r_n == 32'd0) begin
              if (w_row_last) r_a0 <= r_i;
              else            r_i  <= r_i + 32'd1;
            end
          end
        end
        S_RD_B: if (w_done) r_cb <= rdata[7:0];
        S_RD_V: if (w_done) r_t  <= rdata;
        S_WR_V: begin
          if (w_done) begin
            r_left <= w_x;
            r_prev <= r_t;
            if (!w_col_last)     r_j  <= r_j + 32'd1;
            else if (w_row_last) r_a0 <= w_x;
            else                 r_i  <= r_i + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // a0 is already final on entry to FINISH, so idle can rise there.
  assign idle  = setb & ((r_state == S_FINISH) || (r_state == S_DONE));
  assign a0    = r_a0;
  assign valid = r_valid;
  assign addr  = r_addr;
  assign size  = r_size;
  assign write = r_write;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_levenshtein_core.sv
// tb/tb_levenshtein_core.sv - directed edit-distance runs against a byte RAM with optional wait states
// Expected distances are hand-computed for each string pair.

module tb_levenshtein_core;

  logic        clk = 1'b0;
  logic        rstb, setb, idle, valid, write, ready;
  logic [7:0]  pc0;
  logic [31:0] ra0, sp0, s00, a00, a10, a20, a30, a40;
  logic [31:0] a0, addr, wdata, rdata;
  logic [2:0]  size;

  logic [7:0]  mem [65536];
  int          total = 0;
  int          bad = 0;
  int          str_reads = 0;
  int          bad_writes = 0;
  int          stab_err = 0;
  int          wcnt = 0;
  logic        wait_en = 1'b0;
  logic        in_txn = 1'b0;
  logic [67:0] lat;

  levenshtein_core dut (
    .clk(clk), .rstb(rstb), .setb(setb), .idle(idle), .pc0(pc0),
    .ra0(ra0), .sp0(sp0), .s00(s00), .a00(a00), .a10(a10), .a20(a20),
    .a30(a30), .a40(a40), .a0(a0), .addr(addr), .size(size), .valid(valid),
    .write(write), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  // Bus slave: drives ready/rdata on the falling edge, commits writes after the accepting edge.
  always @(negedge clk) begin
    if (rstb) begin
      ready = 1'b0;
      in_txn = 1'b0;
    end else if (ready) begin
      if (lat[34]) begin
        if (lat[33:32] == 2'd2) begin
          for (int k = 0; k < 4; k++) mem[16'(lat[67:36] + 32'(k))] = lat[8*k +: 8];
        end else begin
          mem[lat[51:36]] = lat[7:0];
        end
      end
      ready = 1'b0;
      in_txn = 1'b0;
    end else if (valid) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        lat = {addr, 1'b0, write, size[1:0], wdata};
        wcnt = wait_en ? int'($urandom_range(0, 3)) : 0;
      end else if ({addr, 1'b0, write, size[1:0], wdata} !== lat) begin
        stab_err++;
      end
      if (wcnt == 0) begin
        ready = 1'b1;
        if (size == 3'd2) rdata = {mem[addr[15:0]+16'd3], mem[addr[15:0]+16'd2], mem[addr[15:0]+16'd1], mem[addr[15:0]]};
        else              rdata = {24'd0, mem[addr[15:0]]};
        if (!write && size == 3'd0) str_reads++;
        if (write && (size != 3'd2 || addr < 32'h1F00 || addr >= 32'h2000)) bad_writes++;
      end else begin
        wcnt--;
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[16'(a + 32'(k))] = w[8*k +: 8];
  endtask

  task automatic put_str(input logic [31:0] a, input string s);
    for (int k = 0; k < s.len(); k++) mem[16'(a + 32'(k))] = s[k];
  endtask

  task automatic start(input logic [31:0] ap, input logic [31:0] al, input logic [31:0] bp,
                       input logic [31:0] bl, input logic [7:0] pc);
    setb = 1'b0;
    pc0 = pc; a00 = ap; a10 = al; a20 = bp; a30 = bl;
    repeat (2) @(negedge clk);
    setb = 1'b1;
  endtask

  task automatic run(input string tag, input logic [31:0] ap, input logic [31:0] al,
                     input logic [31:0] bp, input logic [31:0] bl, input logic [7:0] pc,
                     input logic [31:0] exp);
    int cyc;
    start(ap, al, bp, bl, pc);
    cyc = 0;
    while (idle !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    assert (idle === 1'b1) else begin
      bad++;
      $error("FAIL %s_idle observed=%0b expected=1", tag, idle);
    end
    total++;
    assert (a0 === exp) else begin
      bad++;
      $error("FAIL %s_a0 observed=%0d expected=%0d", tag, a0, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    rstb = 1'b1; setb = 1'b0; ready = 1'b0; rdata = 32'd0;
    pc0 = 8'd0; ra0 = 32'h0000_0100; sp0 = 32'h0000_2000; s00 = 32'h1234_5678;
    a00 = '0; a10 = '0; a20 = '0; a30 = '0; a40 = 32'hDEAD_BEEF;

    put_word(32'h1100, 32'h7368_6974);
    put_word(32'h1200, 32'h726D_6F6D);
    put_word(32'h1204, 32'h0000_0075);
    put_word(32'h1300, 32'h6869_7421);
    put_word(32'h1304, 32'h0000_0053);
    put_str(32'h1400, "kitten");
    put_str(32'h1500, "sitting");
    put_str(32'h1600, "abcd");
    put_str(32'h1700, "abXd");
    put_str(32'h1800, "flaw");
    put_str(32'h1900, "lawn");
    put_str(32'h1A00, "S");
    put_str(32'h1A10, "s");

    @(negedge clk);
    total++;
    assert ({idle, valid, write, addr, size, wdata, a0} === 100'd0) else begin
      bad++;
      $error("FAIL reset_outputs observed=%h expected=0", {idle, valid, write, addr, size, wdata, a0});
    end
    rstb = 1'b0;
    @(negedge clk);

    run("tihs_momru", 32'h1100, 32'd4, 32'h1200, 32'd5, 8'd0, 32'd5);
    repeat (3) @(negedge clk);
    total++;
    assert ({idle, valid} === 2'b10) else begin
      bad++;
      $error("FAIL done_hold observed=%b expected=10", {idle, valid});
    end

    run("tihs_shit", 32'h1100, 32'd4, 32'h1300, 32'd5, 8'd0, 32'd2);
    str_reads = 0;
    run("m_zero", 32'h1100, 32'd0, 32'h1200, 32'd5, 8'd0, 32'd5);
    total++;
    assert (str_reads === 0) else begin
      bad++;
      $error("FAIL m_zero_reads observed=%0d expected=0", str_reads);
    end
    run("n_zero", 32'h1100, 32'd4, 32'h1200, 32'd0, 8'd0, 32'd4);
    run("identical", 32'h1600, 32'd4, 32'h1600, 32'd4, 8'd0, 32'd0);
    run("one_diff", 32'h1600, 32'd4, 32'h1700, 32'd4, 8'd0, 32'd1);
    run("kitten", 32'h1400, 32'd6, 32'h1500, 32'd7, 8'd0, 32'd3);
    run("flaw_lawn", 32'h1800, 32'd4, 32'h1900, 32'd4, 8'd0, 32'd2);
    run("case", 32'h1A00, 32'd1, 32'h1A10, 32'd1, 8'd0, 32'd1);
    run("bad_pc", 32'h1400, 32'd6, 32'h1500, 32'd7, 8'd1, 32'd0);

    run("pre_abort", 32'h1800, 32'd4, 32'h1900, 32'd4, 8'd0, 32'd2);
    start(32'h1400, 32'd6, 32'h1500, 32'd7, 8'd0);
    repeat (40) @(negedge clk);
    setb = 1'b0;
    @(negedge clk);
    total++;
    assert ({idle, valid, a0} === {2'b00, 32'd2}) else begin
      bad++;
      $error("FAIL abort observed=%b/%0d expected=00/2", {idle, valid}, a0);
    end

    start(32'h1400, 32'd6, 32'h1500, 32'd7, 8'd0);
    repeat (37) @(negedge clk);
    rstb = 1'b1;
    #1;
    total++;
    assert ({idle, valid} === 2'b00) else begin
      bad++;
      $error("FAIL mid_reset observed=%b expected=00", {idle, valid});
    end
    setb = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    run("after_reset", 32'h1400, 32'd6, 32'h1500, 32'd7, 8'd0, 32'd3);

    wait_en = 1'b1;
    run("wait_tihs_momru", 32'h1100, 32'd4, 32'h1200, 32'd5, 8'd0, 32'd5);
    run("wait_tihs_shit", 32'h1100, 32'd4, 32'h1300, 32'd5, 8'd0, 32'd2);
    run("wait_kitten", 32'h1400, 32'd6, 32'h1500, 32'd7, 8'd0, 32'd3);
    wait_en = 1'b0;

    total++;
    assert (stab_err === 0) else begin
      bad++;
      $error("FAIL bus_stable observed=%0d expected=0", stab_err);
    end
    total++;
    assert (bad_writes === 0) else begin
      bad++;
      $error("FAIL write_region observed=%0d expected=0", bad_writes);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/levenshtein_core.md
# levenshtein_core

Hardware Levenshtein (edit-distance) engine acting as a bus master on the shared 32-bit memory bus. A host loads string pointers and lengths through the argument ports, raises `setb`, and waits for `idle`. The core then reads both byte strings from memory, keeps one dynamic-programming row as a word array on a stack below `sp0`, and returns the distance in `a0`. It sits beside the system RAM (window 0x1000–0x1FFF) and replaces a software call to `levenshtein(a_p, a_len, b_p, b_len)`.

## Interface
- No parameters.
- `clk` — in, 1 — single clock; all state changes on its rising edge.
- `rstb` — in, 1 — reset, asynchronous, active-high.
- `setb` — in, 1 — run enable. Low: load/hold arguments. High: run.
- `idle` — out, 1 — high only when the computation is complete.
- `pc0` — in, 8 — entry point. Only 0 is defined; any other value completes immediately with `a0`=0.
- `ra0` — in, 32 — return address. Captured at load and has no effect.
- `sp0` — in, 32 — stack top. The row buffer is placed below it.
- `s00` — in, 32 — callee-saved register value. Captured at load and unused.
- `a00` — in, 32 — `a_p`, byte address of string a.
- `a10` — in, 32 — `a_len`.
- `a20` — in, 32 — `b_p`.
- `a30` — in, 32 — `b_len`.
- `a40` — in, 32 — captured at load and unused.
- `a0` — out, 32 — result register.
- `addr` — out, 32 — bus byte address.
- `size` — out, 3 — access size: 0 = byte, 1 = half, 2 = word. Bit 2 is always 0.
- `valid` — out, 1 — bus request.
- `write` — out, 1 — 1 = write, 0 = read.
- `wdata` — out, 32 — write data.
- `rdata` — in, 32 — read data, right-aligned. A byte read returns the byte in [7:0].
- `ready` — in, 1 — transfer complete.

## Operation
- States: LOAD, INIT, ROWSTART, RD_A, RD_B, RD_V, WR_V, FINISH, DONE.
- While `setb`=0, from any state:
  - go to LOAD and latch all *0 inputs every cycle;
  - `idle`=0, `valid`=0;
  - `a0` holds its value.
- The first cycle with `setb`=1 leaves LOAD.
- Let m=`a_len`, n=`b_len`, and base = `sp0` − 4·(n+1). The row word at index j is at base+4j.
- INIT: write v[j]=j for j=0..n, ascending.
- For i=1..m:
  - set prev=v[0], then write v[0]=i;
  - read byte ca=mem[`a_p`+i−1];
  - left=i.
- Inner loop, for j=1..n:
  - read cb=mem[`b_p`+j−1];
  - read t=v[j];
  - compute x=min(t+1, left+1, prev+(ca≠cb));
  - write v[j]=x;
  - set left=x, prev=t.
- Comparison is unsigned 8-bit and case-sensitive. 'S' ≠ 's'.
- All arithmetic is 32-bit unsigned. Lengths are treated as unsigned.
- FINISH: `a0` = v[n], obtained by a read or the last `left`. Then go to DONE.
- Edge cases:
  - m=0 → `a0`=n, with no string reads.
  - n=0 → `a0`=m, but INIT still writes v[0].
- DONE: `idle`=1 and `valid`=0, held until `setb` falls.
- Only string bytes and the row array are accessed. No other memory is written.

## Timing
- Reset values: `idle`=0, `valid`=0, `write`=0, `addr`=0, `size`=0, `wdata`=0, `a0`=0. State = LOAD.
- Bus handshake:
  - One outstanding transaction at a time.
  - `valid`, `addr`, `size`, `write`, `wdata` assert together and stay stable until a rising edge where `ready`=1.
  - `rdata` is sampled at that edge.
  - `valid` drops for at least the following cycle before the next request.
  - Wait states of any length are allowed.
- Latency is data-dependent: roughly (n+1) + m·(3+3n) bus transactions, each ≥2 cycles.
- `idle` rises the cycle after the final transaction completes. `a0` is valid in the same cycle `idle` rises.
- Mid-run `setb` fall aborts the computation:
  - any bus request is dropped at the next edge;
  - `a0` is unchanged.
- Mid-run reset returns all outputs to their reset values immediately.
- A new run needs `setb` low for ≥1 cycle, then high.

## Test plan
- Memory at 0x1100 = word 0x73686974; 0x1200/0x1204 = 0x75726D6F6D (low/high words); `sp0`=0x2000. Run with a=(0x1100,4), b=(0x1200,5) → `idle`=1 and `a0`=5.
- Same string a; b at 0x1300 holds 0x536869 7421 packed as the 64-bit value "Shit!", length 5 → `a0`=2.
- `a_len`=0, `b_len`=5 → `a0`=5, no string reads. `a_len`=4, `b_len`=0 → `a0`=4.
- Identical 4-byte strings → `a0`=0. Strings differing in a single byte → 1.
- Reset asserted mid-run → `valid`=0 and `idle`=0 immediately. Rerun gives the correct result.
- RAM with random 0–3 wait states → same results. Bus fields stay stable while `valid`=1 and `ready`=0.
